// File: rtl/prog_run_pkg.sv
// Shared types and constants for the program-run sequencer: the FSM state
// encoding and the width and saturation value of the RUN cycle counter.
package prog_run_pkg;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_ARM    = 3'd2,
    S_RUN    = 3'd3,
    S_RECORD = 3'd4,
    S_DONE   = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

endpackage

// File: rtl/prog_run_sequencer_if.sv
// Bundles the host-side controls (Go/Abort), the core handshake
// (Start/Ack) and the status/result outputs of the sequencer.
// master: the sequencer side. slave: the host/core side.
interface prog_run_sequencer_if #(
  parameter int PW = 2
);
  import prog_run_pkg::*;

  logic             Go;
  logic             Abort;
  logic             Ack;
  logic             Start;
  logic [PW-1:0]    ProgIdx;
  logic             Busy;
  logic [CNT_W-1:0] CycleCount;
  logic             CountValid;
  logic             AllDone;
  logic             TimedOut;

  modport master (
    input  Go, Abort, Ack,
    output Start, ProgIdx, Busy, CycleCount, CountValid, AllDone, TimedOut
  );

  modport slave (
    output Go, Abort, Ack,
    input  Start, ProgIdx, Busy, CycleCount, CountValid, AllDone, TimedOut
  );

endinterface

// File: rtl/prog_run_sequencer_sat_counter.sv
// Up-counter with synchronous clear, count enable and saturation at
// all-ones. Clear wins over enable. Used to time each program's RUN phase.
module sat_counter
  import prog_run_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, else increment unless already saturated.
  always_comb begin
    // NOTE: default assignment first so every path assigns cnt_d; no latch.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignment for state so all flops update together.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/prog_run_sequencer.sv
// Runs NUM_PROGS programs on the processor core back to back. Each launch
// holds Start for START_CYCLES cycles, spends one ARM cycle masking the Ack
// left over from the previous halt, then times the RUN phase until Ack or
// TIMEOUT. All outputs are registered; Ack never reaches Start through logic.
module prog_run_sequencer
  import prog_run_pkg::*;
#(
  parameter int               NUM_PROGS    = 3,
  parameter int               PW           = 2,
  parameter int               START_CYCLES = 2,
  parameter logic [CNT_W-1:0] TIMEOUT      = 16'hFFFF
) (
  input  logic                 Clk,
  input  logic                 Reset,
  prog_run_sequencer_if.master bus
);

  localparam int          LW          = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [LW-1:0] LAST_LAUNCH = LW'(START_CYCLES - 1);
  localparam logic [PW-1:0] LAST_PROG   = PW'(NUM_PROGS - 1);

  state_e           state_q;
  logic [LW-1:0]    launch_cnt_q;
  logic [PW-1:0]    prog_idx_q;
  logic [CNT_W-1:0] cycle_count_q;
  logic             start_q;
  logic             busy_q;
  logic             count_valid_q;
  logic             all_done_q;
  logic             timed_out_q;

  logic [CNT_W-1:0] run_cnt;
  logic             run_clr;
  logic             run_en;

  // Counter is held at 0 throughout LAUNCH, so it leaves ARM at 0 and the
  // first RUN cycle reads 1.
  assign run_clr = (state_q == S_LAUNCH);
  assign run_en  = (state_q == S_ARM) || (state_q == S_RUN);

  sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk   (Clk),
    .rst   (Reset),
    .clr_i (run_clr),
    .en_i  (run_en),
    .cnt_o (run_cnt)
  );

  // Sequencer FSM with registered Moore outputs updated alongside the state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      launch_cnt_q  <= '0;
      prog_idx_q    <= '0;
      cycle_count_q <= '0;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      count_valid_q <= 1'b0;
      all_done_q    <= 1'b0;
      timed_out_q   <= 1'b0;
    end else begin
      count_valid_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_FAULT: begin
          // Abort beats Go; otherwise Go starts a fresh run from program 0.
          if (bus.Go && !bus.Abort) begin
            state_q      <= S_LAUNCH;
            prog_idx_q   <= '0;
            all_done_q   <= 1'b0;
            timed_out_q  <= 1'b0;
            launch_cnt_q <= '0;
            start_q      <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        default: begin
          if (bus.Abort) begin
            // Cancel: drop Start and Busy; results and flags stay as they are.
            state_q <= S_IDLE;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            case (state_q)
              S_LAUNCH: begin
                if (launch_cnt_q == LAST_LAUNCH) begin
                  state_q <= S_ARM;
                  start_q <= 1'b0;
                end else begin
                  launch_cnt_q <= launch_cnt_q + 1'b1;
                end
              end
              S_ARM: begin
                state_q <= S_RUN;
              end
              S_RUN: begin
                // Ack has priority over a timeout seen in the same cycle.
                if (bus.Ack) begin
                  cycle_count_q <= run_cnt;
                  count_valid_q <= 1'b1;
                  state_q       <= S_RECORD;
                end else if (run_cnt == TIMEOUT) begin
                  timed_out_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_FAULT;
                end
              end
              S_RECORD: begin
                if (prog_idx_q == LAST_PROG) begin
                  all_done_q <= 1'b1;
                  busy_q     <= 1'b0;
                  state_q    <= S_DONE;
                end else begin
                  prog_idx_q   <= prog_idx_q + 1'b1;
                  launch_cnt_q <= '0;
                  start_q      <= 1'b1;
                  state_q      <= S_LAUNCH;
                end
              end
              default: begin
                // Unused encoding: return to a quiet IDLE.
                state_q <= S_IDLE;
                start_q <= 1'b0;
                busy_q  <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign bus.Start      = start_q;
  assign bus.ProgIdx    = prog_idx_q;
  assign bus.Busy       = busy_q;
  assign bus.CycleCount = cycle_count_q;
  assign bus.CountValid = count_valid_q;
  assign bus.AllDone    = all_done_q;
  assign bus.TimedOut   = timed_out_q;

endmodule

// File: tb/tb_prog_run_sequencer.sv
// Bench for prog_run_sequencer: a core model answers each launch with Ack
// after a planned number of RUN cycles; the expected per-program records are
// computed from the plan and checked by a monitor on every CountValid.
module tb_prog_run_sequencer;
  import prog_run_pkg::*;

  localparam int NUM_PROGS    = 3;
  localparam int PW           = 2;
  localparam int START_CYCLES = 2;
  localparam int TIMEOUT      = 20;

  typedef struct {
    int idx;
    int cnt;
  } rec_t;

  typedef struct {
    int k;
    bit hold;
  } plan_t;

  logic Clk = 1'b0;
  logic Reset;

  prog_run_sequencer_if #(.PW(PW)) bus ();

  prog_run_sequencer #(
    .NUM_PROGS    (NUM_PROGS),
    .PW           (PW),
    .START_CYCLES (START_CYCLES),
    .TIMEOUT      (16'(TIMEOUT))
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  rec_t  exp_q[$];
  plan_t core_q[$];
  int    plan_k[NUM_PROGS];
  bit    plan_hold[NUM_PROGS];
  int    model_cc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge Clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Core model: after the ARM cycle, count RUN cycles and raise Ack at k.
  // Hold mode keeps Ack high afterwards, like a halted core.
  initial begin : core_model
    bit    prev_start;
    plan_t p;
    prev_start = 1'b0;
    bus.Ack    = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      if (prev_start && !bus.Start && bus.Busy) begin
        if (core_q.size() > 0) p = core_q.pop_front();
        else p = '{k: 100000, hold: 1'b0};
        for (int j = 1; j <= p.k; j++) begin
          @(posedge Clk);
          #1;
          if (!bus.Busy || bus.Start) break;
          bus.Ack = (j == p.k);
          if (j == p.k) begin
            if (!p.hold) begin
              @(posedge Clk);
              #1;
              bus.Ack = 1'b0;
            end
            break;
          end
        end
      end
      prev_start = bus.Start;
    end
  end

  // Monitor: scoreboard on CountValid, Start width, and RUN latencies.
  bit prev_start_m = 1'b0;
  bit prev_to      = 1'b0;
  int start_len    = 0;
  int fall_cyc     = 0;
  always @(negedge Clk) begin
    rec_t e;
    if (Reset) begin
      prev_start_m = 1'b0;
      prev_to      = 1'b0;
      start_len    = 0;
    end else begin
      if (bus.CountValid) begin
        check("sb_has_entry", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rec_idx", bus.ProgIdx, e.idx);
          check("rec_count", bus.CycleCount, e.cnt);
          check("rec_latency", cyc - fall_cyc, e.cnt + 1);
        end
      end
      if (bus.Start) begin
        start_len++;
      end else if (start_len > 0) begin
        if (bus.Busy) check("start_len", start_len, START_CYCLES);
        start_len = 0;
      end
      if (bus.Start && !bus.Busy) check("start_implies_busy", bus.Busy, 1);
      if (prev_start_m && !bus.Start && bus.Busy) fall_cyc = cyc;
      if (!prev_to && bus.TimedOut) check("timeout_latency", cyc - fall_cyc, TIMEOUT + 1);
      prev_start_m = bus.Start;
      prev_to      = bus.TimedOut;
    end
  end

  // One full Go run from plan_k/plan_hold; expectations follow the plan:
  // a program with k <= TIMEOUT records k, otherwise the run faults there.
  task automatic do_run(input bit go_noise);
    bit exp_fault;
    int last_idx;
    int n;
    plan_t pl;
    exp_fault = 1'b0;
    last_idx  = 0;
    for (int p = 0; p < NUM_PROGS; p++) begin
      pl.k    = plan_k[p];
      pl.hold = plan_hold[p];
      core_q.push_back(pl);
      last_idx = p;
      if (plan_k[p] <= TIMEOUT) begin
        exp_q.push_back('{idx: p, cnt: plan_k[p]});
        model_cc = plan_k[p];
      end else begin
        exp_fault = 1'b1;
        break;
      end
    end
    @(negedge Clk);
    bus.Go = 1'b1;
    @(negedge Clk);
    bus.Go = 1'b0;
    check("go_start", bus.Start, 1);
    check("go_busy", bus.Busy, 1);
    check("go_idx", bus.ProgIdx, 0);
    check("go_alldone_clr", bus.AllDone, 0);
    check("go_timedout_clr", bus.TimedOut, 0);
    n = 0;
    while (bus.Busy && n < 1000) begin
      @(negedge Clk);
      bus.Go = go_noise && bus.Busy && ($urandom_range(0, 5) == 0);
      n++;
    end
    bus.Go = 1'b0;
    check("run_ends", bus.Busy, 0);
    check("end_alldone", bus.AllDone, !exp_fault);
    check("end_timedout", bus.TimedOut, exp_fault);
    check("end_idx", bus.ProgIdx, last_idx);
    check("end_cyclecount", bus.CycleCount, model_cc);
    check("end_sb_empty", exp_q.size(), 0);
    repeat (3) @(negedge Clk);
    check("hold_start", bus.Start, 0);
    check("hold_busy", bus.Busy, 0);
    check("hold_alldone", bus.AllDone, !exp_fault);
    check("hold_idx", bus.ProgIdx, last_idx);
  endtask

  initial begin : main
    int n;
    Reset     = 1'b1;
    bus.Go    = 1'b0;
    bus.Abort = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_start", bus.Start, 0);
    check("rst_busy", bus.Busy, 0);
    check("rst_idx", bus.ProgIdx, 0);
    check("rst_cc", bus.CycleCount, 0);
    check("rst_cv", bus.CountValid, 0);
    check("rst_alldone", bus.AllDone, 0);
    check("rst_timedout", bus.TimedOut, 0);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    check("idle_busy", bus.Busy, 0);
    check("idle_start", bus.Start, 0);

    // Basic three-program run.
    plan_k = '{5, 12, 3}; plan_hold = '{0, 0, 0};
    do_run(1'b0);

    // Abort in DONE changes nothing.
    bus.Abort = 1'b1;
    @(negedge Clk);
    bus.Abort = 1'b0;
    @(negedge Clk);
    check("done_abort_alldone", bus.AllDone, 1);
    check("done_abort_idx", bus.ProgIdx, NUM_PROGS - 1);

    // Ack held from the previous halt across LAUNCH/ARM; k=1 boundary last.
    plan_k = '{5, 7, 1}; plan_hold = '{1, 1, 1};
    do_run(1'b0);

    // Timeout on program 0; CycleCount keeps the previous run's value.
    plan_k = '{30, 1, 1}; plan_hold = '{0, 0, 0};
    do_run(1'b0);

    // Ack in the same cycle as counter==TIMEOUT: Ack wins.
    plan_k = '{20, 20, 19}; plan_hold = '{0, 1, 0};
    do_run(1'b0);

    // Fault on a middle program.
    plan_k = '{3, 21, 4}; plan_hold = '{0, 0, 0};
    do_run(1'b0);

    // Abort in the same cycle as Ack during program 1.
    core_q.push_back('{k: 4, hold: 1'b0});
    core_q.push_back('{k: 6, hold: 1'b0});
    exp_q.push_back('{idx: 0, cnt: 4});
    model_cc = 4;
    @(negedge Clk);
    bus.Go = 1'b1;
    @(negedge Clk);
    bus.Go = 1'b0;
    n = 0;
    while (!(bus.ProgIdx == 1 && bus.Ack && bus.Busy && !bus.Start) && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check("abort_reached_ack", bus.Ack, 1);
    bus.Abort = 1'b1;
    @(negedge Clk);
    bus.Abort = 1'b0;
    check("abort_busy", bus.Busy, 0);
    check("abort_start", bus.Start, 0);
    check("abort_cv", bus.CountValid, 0);
    check("abort_idx", bus.ProgIdx, 1);
    check("abort_alldone", bus.AllDone, 0);
    check("abort_timedout", bus.TimedOut, 0);
    check("abort_cc", bus.CycleCount, model_cc);
    check("abort_sb_empty", exp_q.size(), 0);

    // Abort in IDLE has no effect; Abort beats Go.
    bus.Abort = 1'b1;
    repeat (2) @(negedge Clk);
    check("idle_abort_idx", bus.ProgIdx, 1);
    bus.Go = 1'b1;
    @(negedge Clk);
    bus.Go    = 1'b0;
    bus.Abort = 1'b0;
    check("abort_beats_go_busy", bus.Busy, 0);
    check("abort_beats_go_start", bus.Start, 0);

    // Asynchronous reset in the middle of LAUNCH.
    @(negedge Clk);
    bus.Go = 1'b1;
    @(negedge Clk);
    bus.Go = 1'b0;
    check("pre_reset_start", bus.Start, 1);
    #1;
    Reset = 1'b1;
    #1;
    check("areset_start", bus.Start, 0);
    check("areset_busy", bus.Busy, 0);
    check("areset_idx", bus.ProgIdx, 0);
    check("areset_cc", bus.CycleCount, 0);
    check("areset_cv", bus.CountValid, 0);
    check("areset_alldone", bus.AllDone, 0);
    check("areset_timedout", bus.TimedOut, 0);
    model_cc = 0;
    core_q.delete();
    exp_q.delete();
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    check("post_reset_busy", bus.Busy, 0);
    check("post_reset_start", bus.Start, 0);

    // Randomized runs with Go noise while busy.
    for (int r = 0; r < 20; r++) begin
      for (int p = 0; p < NUM_PROGS; p++) begin
        plan_k[p]    = $urandom_range(1, 24);
        plan_hold[p] = $urandom_range(0, 1);
      end
      do_run(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_run_sequencer.md
Name: prog_run_sequencer

Overview:
- Drives the processor core's Start input and consumes its Ack (done) output.
- Runs NUM_PROGS programs back to back, measuring each program's cycle count and enforcing a timeout.
- Sits directly upstream of the processor top level, between the test harness/host and the core.
- Ignores the stale Ack left over from the previous program's halt while the next program is launched.

Parameters:
NUM_PROGS, 3, number of programs run per Go; legal range 1..2**PW
PW, 2, width of ProgIdx
START_CYCLES, 2, cycles Start is held high per launch; must be >= 1
TIMEOUT, 16'hFFFF, max RUN-phase count before fault; range 1..16'hFFFF

Ports:
Clk  in  1  clock, posedge only
Reset  in  1  asynchronous, active-high reset
Go  in  1  request a full run; sampled only in IDLE, DONE or FAULT
Abort  in  1  synchronous cancel of the current run
Ack  in  1  done flag from the processor core
Start  out  1  start-next-program strobe to the core
ProgIdx  out  PW  index of the program being run or last run
Busy  out  1  high in LAUNCH, ARM, RUN and RECORD
CycleCount  out  16  latched cycle count of the last completed program
CountValid  out  1  one-cycle pulse when CycleCount is updated
AllDone  out  1  level; all programs completed
TimedOut  out  1  level; sticky fault flag

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, launch counter=0, counter=0.
  - All outputs are 0 during and after reset: Start, ProgIdx, Busy, CycleCount, CountValid, AllDone, TimedOut.
- State machine is Moore. Outputs derive from registered state plus registers only; there are no combinational Ack-to-Start paths.
- States: IDLE, LAUNCH, ARM, RUN, RECORD, DONE, FAULT.
- IDLE, and DONE/FAULT when Go=1:
  - next state LAUNCH, ProgIdx<=0, AllDone<=0, TimedOut<=0.
  - Go=0 means stay in the current state.
- LAUNCH:
  - Start=1 for exactly START_CYCLES cycles (launch counter counts them), then ARM.
  - counter<=0 on the LAUNCH->ARM transition.
  - Ack ignored.
- ARM:
  - exactly 1 cycle, Start=0, Ack ignored. This masks Ack still high from the prior halt.
  - counter increments; next state RUN.
- RUN:
  - counter increments each posedge, saturating at 16'hFFFF.
  - In ARM the counter is 0, so the first RUN cycle sees 1.
  - If Ack=1 is sampled while in RUN: CycleCount<=counter (pre-increment value), next state RECORD.
  - Otherwise, if counter==TIMEOUT: TimedOut<=1, next state FAULT.
  - Ack takes priority over timeout in the same cycle.
- RECORD:
  - 1 cycle, CountValid=1.
  - If ProgIdx==NUM_PROGS-1: AllDone<=1, next state DONE.
  - Otherwise ProgIdx<=ProgIdx+1, next state LAUNCH.
  - ProgIdx never wraps within a run.
- DONE / FAULT:
  - Busy=0, Start=0; ProgIdx holds.
  - CycleCount holds its last value; it is not updated on a fault.
- Abort:
  - From LAUNCH/ARM/RUN/RECORD, next state is IDLE with Start=0 the next cycle.
  - Overrides Ack, timeout and RECORD; CountValid is suppressed that cycle.
  - AllDone and TimedOut are unchanged. ProgIdx holds.
  - Abort in IDLE/DONE/FAULT has no effect. Abort beats Go if both are high.
- Go while Busy is ignored (not queued).
- Reset mid-run aborts immediately and asynchronously with all outputs at 0. The core sees Start drop at once.

Decomposition:
- Package prog_run_pkg:
  - typedef enum logic[2:0] for the states.
  - localparam CNT_W=16 and the saturation value CNT_MAX.
- Sub-module sat_counter:
  - CNT_W-bit counter with synchronous clear, enable and saturation, plus async Reset.
  - Reused for the RUN counter; the launch counter stays inline.

Test Plan:
1. Reset then Go=1 for 1 cycle, NUM_PROGS=3; core model raises Ack on the 5th, 12th and 3rd RUN cycle -> Start is high 2 cycles per launch, three CountValid pulses with CycleCount 5, 12, 3, ProgIdx 0,1,2, then AllDone=1, Busy=0.
2. Ack held high from the prior halt through LAUNCH and ARM, dropping at RUN cycle 1 and rising at RUN cycle 7 -> no early RECORD, CycleCount=7.
3. TIMEOUT=20, Ack never rises -> TimedOut=1 after RUN cycle 20, state FAULT, CountValid never pulses, CycleCount unchanged; a following Go clears TimedOut and restarts at ProgIdx=0.
4. Ack and counter==TIMEOUT occur in the same cycle (TIMEOUT=8, Ack at RUN cycle 8) -> RECORD with CycleCount=8, TimedOut=0.
5. Abort asserted in the same cycle as Ack during program 1 -> IDLE next cycle, CountValid=0, ProgIdx=1, Start=0; Go pulses while Busy produce no effect.
6. Reset asserted asynchronously mid-LAUNCH (between clock edges) -> Start and Busy fall before the next posedge, all outputs 0, state IDLE.
